// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing: pixel coordinates, sync/blank and colour to the pins one pixel period after DrawX/DrawY, plus a per-frame tick.
// Free-running with no backpressure; defining TEST_PATTERN_EN adds test_sel, which switches the colour source to vertical bars.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
`ifdef TEST_PATTERN_EN
   input  logic       test_sel,
`endif
   input  logic [7:0] Red_in,
   input  logic [7:0] Green_in,
   input  logic [7:0] Blue_in,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       pixel_en,
   output logic       hs,
   output logic       vs,
   output logic       blank_n,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0]       V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0]       V_ACT_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0]       HS_FIRST   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]       VS_FIRST   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_q, pix_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             blank_q, blank_d;
   logic [7:0]       r_q, r_d;
   logic [7:0]       g_q, g_d;
   logic [7:0]       b_q, b_d;
   logic             tick_q, tick_d;

   logic             active;
   logic [7:0]       src_r, src_g, src_b;

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      // Registered strobe is high exactly while div_q sits at its last count.
      pix_d = (div_d == DIV_LAST);

      x_d = x_q;
      y_d = y_q;
      if (pix_q) begin
         if (x_q == H_LAST) begin
            x_d = 10'd0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_comb begin
      src_r = Red_in;
      src_g = Green_in;
      src_b = Blue_in;
`ifdef TEST_PATTERN_EN
      if (test_sel) begin
         src_r = {8{x_q[8]}};
         src_g = {8{x_q[7]}};
         src_b = {8{x_q[6]}};
      end
`endif
   end

   always_comb begin
      active  = (x_q < H_ACT) && (y_q < V_ACT);
      hs_d    = hs_q;
      vs_d    = vs_q;
      blank_d = blank_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      if (pix_q) begin
         hs_d    = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
         vs_d    = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
         blank_d = active;
         r_d     = active ? src_r : 8'd0;
         g_d     = active ? src_g : 8'd0;
         b_d     = active ? src_b : 8'd0;
      end
      // Lands on the same edge that moves the counters to the first blank line.
      tick_d = pix_q && (x_q == H_LAST) && (y_q == V_ACT_LAST);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         div_q   <= '0;
         pix_q   <= 1'b0;
         x_q     <= 10'd0;
         y_q     <= 10'd0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         r_q     <= 8'd0;
         g_q     <= 8'd0;
         b_q     <= 8'd0;
         tick_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         pix_q   <= pix_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         tick_q  <= tick_d;
      end
   end

   assign DrawX      = x_q;
   assign DrawY      = y_q;
   assign pixel_en   = pix_q;
   assign hs         = hs_q;
   assign vs         = vs_q;
   assign blank_n    = blank_q;
   assign VGA_R      = r_q;
   assign VGA_G      = g_q;
   assign VGA_B      = b_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing, vertical timing shortened to a 6-line frame.
module tb_vga_timing_gen;

   localparam int VA = 2, VF = 1, VS = 2, VB = 1;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME_CLK = 800 * VT * 2;
   localparam int NV = 13;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] r, g, b;
      logic       ehs, evs, ebl;
      logic [7:0] er, eg, eb;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [7:0] Red_in, Green_in, Blue_in;
   logic [9:0] DrawX, DrawY;
   logic       pixel_en, hs, vs, blank_n, frame_tick;
   logic [7:0] VGA_R, VGA_G, VGA_B;
`ifdef TEST_PATTERN_EN
   logic       test_sel;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   vga_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
`ifdef TEST_PATTERN_EN
      .test_sel(test_sel),
`endif
      .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
      .DrawX(DrawX), .DrawY(DrawY), .pixel_en(pixel_en),
      .hs(hs), .vs(vs), .blank_n(blank_n),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .frame_tick(frame_tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " DrawX"}, 32'(DrawX), 0);
      check({tag, " DrawY"}, 32'(DrawY), 0);
      check({tag, " pixel_en"}, 32'(pixel_en), 0);
      check({tag, " hs"}, 32'(hs), 1);
      check({tag, " vs"}, 32'(vs), 1);
      check({tag, " blank_n"}, 32'(blank_n), 0);
      check({tag, " rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 0);
      check({tag, " frame_tick"}, 32'(frame_tick), 0);
   endtask

   // Stops on the negedge of the pixel_en cycle whose coordinates are (x,y).
   task automatic wait_pix(input int x, input int y, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLK && !ok; i++) begin
         @(negedge Clk);
         if (pixel_en && DrawX == 10'(x) && DrawY == 10'(y)) ok = 1'b1;
      end
   endtask

   vec_t vecs [NV];

   initial begin
      bit ok;
      int lo;
      int first_x;
      int t [3];

      vecs[0]  = '{2,   0, 8'h11, 8'h22, 8'h33, 1, 1, 1, 8'h11, 8'h22, 8'h33};
      vecs[1]  = '{639, 0, 8'hCA, 8'hC9, 8'h2E, 1, 1, 1, 8'hCA, 8'hC9, 8'h2E};
      vecs[2]  = '{640, 0, 8'hCA, 8'hC9, 8'h2E, 1, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[3]  = '{655, 0, 8'h77, 8'h77, 8'h77, 1, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[4]  = '{656, 0, 8'h77, 8'h77, 8'h77, 0, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[5]  = '{751, 0, 8'h77, 8'h77, 8'h77, 0, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[6]  = '{752, 0, 8'h77, 8'h77, 8'h77, 1, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[7]  = '{799, 0, 8'h77, 8'h77, 8'h77, 1, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[8]  = '{0,   1, 8'h5A, 8'hA5, 8'h0F, 1, 1, 1, 8'h5A, 8'hA5, 8'h0F};
      vecs[9]  = '{100, 2, 8'hFF, 8'hFF, 8'hFF, 1, 1, 0, 8'h00, 8'h00, 8'h00};
      vecs[10] = '{100, 3, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 8'h00, 8'h00, 8'h00};
      vecs[11] = '{799, 4, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 8'h00, 8'h00, 8'h00};
      vecs[12] = '{0,   5, 8'hFF, 8'hFF, 8'hFF, 1, 1, 0, 8'h00, 8'h00, 8'h00};

      Reset_n  = 1'b0;
      Red_in   = 8'h00;
      Green_in = 8'h00;
      Blue_in  = 8'h00;
`ifdef TEST_PATTERN_EN
      test_sel = 1'b0;
`endif
      repeat (3) @(negedge Clk);
      check_reset_state("reset");

      // Release, then the divider strobe and first coordinate steps.
      Reset_n = 1'b1;
      @(negedge Clk);
      check("first pixel_en", 32'(pixel_en), 1);
      check("first DrawX", 32'(DrawX), 0);
      @(negedge Clk);
      check("gap pixel_en", 32'(pixel_en), 0);
      check("second DrawX", 32'(DrawX), 1);
      @(negedge Clk);
      check("second pixel_en", 32'(pixel_en), 1);

      for (int i = 0; i < NV; i++) begin
         wait_pix(vecs[i].x, vecs[i].y, ok);
         check($sformatf("v%0d reached", i), 32'(ok), 1);
         Red_in   = vecs[i].r;
         Green_in = vecs[i].g;
         Blue_in  = vecs[i].b;
         @(negedge Clk);
         check($sformatf("v%0d hs", i), 32'(hs), 32'(vecs[i].ehs));
         check($sformatf("v%0d vs", i), 32'(vs), 32'(vecs[i].evs));
         check($sformatf("v%0d blank_n", i), 32'(blank_n), 32'(vecs[i].ebl));
         check($sformatf("v%0d rgb", i), 32'({VGA_R, VGA_G, VGA_B}),
               32'({vecs[i].er, vecs[i].eg, vecs[i].eb}));
      end

      // hs pulse width and position over one full line.
      wait_pix(0, 0, ok);
      check("line start reached", 32'(ok), 1);
      lo = 0;
      first_x = -1;
      for (int p = 0; p < 800; p++) begin
         @(negedge Clk);
         if (!hs) begin
            if (lo == 0) first_x = int'(DrawX);
            lo++;
         end
         @(negedge Clk);
      end
      check("hs low periods", 32'(lo), 96);
      check("hs first low DrawX", 32'(first_x), 657);
      check("line wrap DrawY", 32'(DrawY), 1);

      // vs pulse width over one full frame.
      lo = 0;
      for (int p = 0; p < 800 * VT; p++) begin
         @(negedge Clk);
         if (!vs) lo++;
         @(negedge Clk);
      end
      check("vs low periods", 32'(lo), 1600);

      // Three frame ticks: width, position and spacing.
      for (int k = 0; k < 3; k++) begin
         ok = 1'b0;
         for (int i = 0; i < FRAME_CLK + 100 && !ok; i++) begin
            @(negedge Clk);
            if (frame_tick) ok = 1'b1;
         end
         check($sformatf("tick%0d seen", k), 32'(ok), 1);
         t[k] = cyc;
         check($sformatf("tick%0d DrawX", k), 32'(DrawX), 0);
         check($sformatf("tick%0d DrawY", k), 32'(DrawY), VA);
         @(negedge Clk);
         check($sformatf("tick%0d width", k), 32'(frame_tick), 0);
         if (k > 0) check($sformatf("tick%0d spacing", k), 32'(t[k] - t[k-1]), FRAME_CLK);
      end

      // Reset in the middle of a line.
      wait_pix(300, 1, ok);
      check("mid-frame reached", 32'(ok), 1);
      Reset_n = 1'b0;
      @(negedge Clk);
      check_reset_state("midreset");
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      check("restart pixel_en", 32'(pixel_en), 1);
      check("restart XY", 32'({DrawX, DrawY}), 0);
      @(negedge Clk);
      check("restart DrawX", 32'(DrawX), 1);
      check("restart DrawY", 32'(DrawY), 0);

`ifdef TEST_PATTERN_EN
      test_sel = 1'b1;
      Red_in   = 8'h12;
      Green_in = 8'h34;
      Blue_in  = 8'h56;
      wait_pix(64, 0, ok);
      @(negedge Clk);
      check("bar 64", 32'({VGA_R, VGA_G, VGA_B}), 32'h0000FF);
      wait_pix(448, 0, ok);
      @(negedge Clk);
      check("bar 448", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFFFFF);
      wait_pix(64, 4, ok);
      @(negedge Clk);
      check("bar blank", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
